// File: rtl/smem_rd_arb_pkg.sv
// Shared types and mdata helpers for the SMEM read arbiter.
// mdata layout is {zero pad, requester index, requester tag}.
package smem_rd_arb_pkg;

    localparam int SMEM_LINE_ADDR_W = 42;
    localparam int SMEM_MDATA_W     = 16;

    typedef struct packed {
        logic [SMEM_LINE_ADDR_W-1:0] addr;
        logic [SMEM_MDATA_W-1:0]     tag;
    } t_smem_rd_req;

    function automatic logic [SMEM_MDATA_W-1:0] mdata_pack(
        input logic [SMEM_MDATA_W-1:0] idx,
        input logic [SMEM_MDATA_W-1:0] tag,
        input int unsigned             tag_w
    );
        logic [SMEM_MDATA_W-1:0] tmask;
        tmask = (16'd1 << tag_w) - 16'd1;
        return (idx << tag_w) | (tag & tmask);
    endfunction

    function automatic logic [SMEM_MDATA_W-1:0] mdata_idx(
        input logic [SMEM_MDATA_W-1:0] mdata,
        input int unsigned             tag_w,
        input int unsigned             idx_w
    );
        return (mdata >> tag_w) & ((16'd1 << idx_w) - 16'd1);
    endfunction

    function automatic logic [SMEM_MDATA_W-1:0] mdata_tag(
        input logic [SMEM_MDATA_W-1:0] mdata,
        input int unsigned             tag_w
    );
        return mdata & ((16'd1 << tag_w) - 16'd1);
    endfunction

endpackage

// File: rtl/smem_rr_picker.sv
// Combinational round-robin one-hot picker: first set bit of elig at or after ptr.
// Zero latency; no state, no backpressure.
module smem_rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         elig,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant
);

    localparam int PW = $clog2(N);

    logic [PW:0] pos;
    logic        found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (PW+1)'(k);
            if (pos >= (PW+1)'(N)) begin
                pos = pos - (PW+1)'(N);
            end
            if (!found && elig[pos[PW-1:0]]) begin
                grant[pos[PW-1:0]] = 1'b1;
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/smem_rd_arbiter.sv
// Round-robin c0 read arbiter with per-requester outstanding limit; 1-cycle request and response latency.
// Grants drop while TX is almost-full; responses have no backpressure. SMEM_RD_ARB_STATS_EN enables issue counters.
module smem_rd_arbiter
    import smem_rd_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_OUTST = 32,
    parameter int TAG_W     = 12
) (
    input  logic                            clk,
    input  logic                            spl_reset_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*42-1:0]           req_addr,
    input  logic [NUM_REQ*TAG_W-1:0]        req_tag,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            spl_tx_rd_almostfull,
    output logic                            afu_tx_rd_valid,
    output logic [41:0]                     afu_tx_rd_addr,
    output logic [15:0]                     afu_tx_rd_mdata,
    input  logic                            spl_rx_rd_valid,
    input  logic [15:0]                     spl_rx_rd_mdata,
    input  logic [511:0]                    spl_rx_data,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [TAG_W-1:0]                rsp_tag,
    output logic [511:0]                    rsp_data,
    output logic                            err_bad_idx,
    output logic [NUM_REQ*32-1:0]           stat_issued
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam logic [CNT_W-1:0] OUTST_LIM = CNT_W'(MAX_OUTST);

    logic [CNT_W-1:0]   outst_q [NUM_REQ];
    logic [CNT_W-1:0]   outst_d [NUM_REQ];
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] elig, grant, hs, dec;
    logic               hs_any;
    logic [IDX_W-1:0]   hs_idx;
    logic [TAG_W-1:0]   tag_sel;
    t_smem_rd_req       tx_req_q, tx_req_d;
    logic               tx_vld_q;

    logic [15:0]        rx_idx_w, rx_tag_w;
    logic               idx_ok, underflow;
    logic [NUM_REQ-1:0] rsp_vld_q, rsp_vld_d;
    logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
    logic [511:0]       rsp_data_q, rsp_data_d;
    logic               err_q, err_d;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_valid[i] && (outst_q[i] < OUTST_LIM);
        end
    end

    smem_rr_picker #(.N(NUM_REQ)) u_pick (
        .elig  (elig),
        .ptr   (ptr_q),
        .grant (grant)
    );

    assign req_ready = spl_tx_rd_almostfull ? '0 : grant;
    assign hs        = req_valid & req_ready;
    assign hs_any    = |hs;

    always_comb begin
        hs_idx   = '0;
        tag_sel  = '0;
        tx_req_d = tx_req_q;
        ptr_d    = ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hs[i]) begin
                hs_idx        = IDX_W'(i);
                tag_sel       = req_tag[i*TAG_W +: TAG_W];
                tx_req_d.addr = req_addr[i*42 +: 42];
            end
        end
        if (hs_any) begin
            tx_req_d.tag = mdata_pack(16'(hs_idx), 16'(tag_sel), TAG_W);
            ptr_d        = (hs_idx == IDX_W'(NUM_REQ-1)) ? '0 : hs_idx + 1'b1;
        end
    end

    // An in-range response to a requester with nothing outstanding is still
    // delivered, but flagged; its counter cannot go below zero.
    always_comb begin
        rx_idx_w   = mdata_idx(spl_rx_rd_mdata, TAG_W, IDX_W);
        rx_tag_w   = mdata_tag(spl_rx_rd_mdata, TAG_W);
        idx_ok     = rx_idx_w < 16'(NUM_REQ);
        rsp_vld_d  = '0;
        dec        = '0;
        underflow  = 1'b0;
        rsp_tag_d  = rsp_tag_q;
        rsp_data_d = rsp_data_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (spl_rx_rd_valid && idx_ok && (rx_idx_w == 16'(i))) begin
                rsp_vld_d[i] = 1'b1;
                dec[i]       = (outst_q[i] != '0);
                underflow    = (outst_q[i] == '0);
            end
        end
        if (|rsp_vld_d) begin
            rsp_tag_d  = rx_tag_w[TAG_W-1:0];
            rsp_data_d = spl_rx_data;
        end
        err_d = err_q | (spl_rx_rd_valid && !idx_ok) | underflow;
        for (int i = 0; i < NUM_REQ; i++) begin
            case ({hs[i], dec[i]})
                2'b10:   outst_d[i] = outst_q[i] + 1'b1;
                2'b01:   outst_d[i] = outst_q[i] - 1'b1;
                default: outst_d[i] = outst_q[i];
            endcase
        end
    end

    always_ff @(posedge clk or negedge spl_reset_n) begin
        if (!spl_reset_n) begin
            ptr_q      <= '0;
            tx_vld_q   <= 1'b0;
            tx_req_q   <= '0;
            rsp_vld_q  <= '0;
            rsp_tag_q  <= '0;
            rsp_data_q <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                outst_q[i] <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            tx_vld_q   <= hs_any;
            tx_req_q   <= tx_req_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_tag_q  <= rsp_tag_d;
            rsp_data_q <= rsp_data_d;
            err_q      <= err_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                outst_q[i] <= outst_d[i];
            end
        end
    end

    assign afu_tx_rd_valid = tx_vld_q;
    assign afu_tx_rd_addr  = tx_req_q.addr;
    assign afu_tx_rd_mdata = tx_req_q.tag;
    assign rsp_valid       = rsp_vld_q;
    assign rsp_tag         = rsp_tag_q;
    assign rsp_data        = rsp_data_q;
    assign err_bad_idx     = err_q;

`ifdef SMEM_RD_ARB_STATS_EN
    logic [31:0] stat_q [NUM_REQ];
    logic [31:0] stat_d [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_d[i]                = stat_q[i] + {31'd0, hs[i]};
            stat_issued[i*32 +: 32]  = stat_q[i];
        end
    end

    always_ff @(posedge clk or negedge spl_reset_n) begin
        if (!spl_reset_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                stat_q[i] <= stat_d[i];
            end
        end
    end
`else
    assign stat_issued = '0;
`endif

endmodule

// File: tb/tb_smem_rd_arbiter.sv
// Directed bench for smem_rd_arbiter: reference round-robin/outstanding model plus TX and RX scoreboards.
module tb_smem_rd_arbiter;

    localparam int N  = 4;
    localparam int TW = 12;
    localparam int MO = 32;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N-1:0]       req_valid;
    logic [N*42-1:0]    req_addr;
    logic [N*TW-1:0]    req_tag;
    logic [N-1:0]       req_ready;
    logic               af;
    logic               tx_vld;
    logic [41:0]        tx_addr;
    logic [15:0]        tx_mdata;
    logic               rxv;
    logic [15:0]        rxm;
    logic [511:0]       rxd;
    logic [N-1:0]       rsp_valid;
    logic [TW-1:0]      rsp_tag;
    logic [511:0]       rsp_data;
    logic               err;
    logic [N*32-1:0]    stat;

    // Three-requester instance: the only shape where an index can be out of range.
    logic               rxv3;
    logic [15:0]        rxm3;
    logic [2:0]         ready3;
    logic               tx_vld3;
    logic [41:0]        tx_addr3;
    logic [15:0]        tx_mdata3;
    logic [2:0]         rsp_valid3;
    logic [TW-1:0]      rsp_tag3;
    logic [511:0]       rsp_data3;
    logic               err3;
    logic [95:0]        stat3;

    always #5 clk = ~clk;

    smem_rd_arbiter #(.NUM_REQ(N), .MAX_OUTST(MO), .TAG_W(TW)) dut (
        .clk(clk), .spl_reset_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_tag(req_tag), .req_ready(req_ready),
        .spl_tx_rd_almostfull(af),
        .afu_tx_rd_valid(tx_vld), .afu_tx_rd_addr(tx_addr), .afu_tx_rd_mdata(tx_mdata),
        .spl_rx_rd_valid(rxv), .spl_rx_rd_mdata(rxm), .spl_rx_data(rxd),
        .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
        .err_bad_idx(err), .stat_issued(stat)
    );

    smem_rd_arbiter #(.NUM_REQ(3), .MAX_OUTST(MO), .TAG_W(TW)) dut3 (
        .clk(clk), .spl_reset_n(rst_n),
        .req_valid(3'b000), .req_addr(126'd0), .req_tag(36'd0), .req_ready(ready3),
        .spl_tx_rd_almostfull(1'b0),
        .afu_tx_rd_valid(tx_vld3), .afu_tx_rd_addr(tx_addr3), .afu_tx_rd_mdata(tx_mdata3),
        .spl_rx_rd_valid(rxv3), .spl_rx_rd_mdata(rxm3), .spl_rx_data(512'd0),
        .rsp_valid(rsp_valid3), .rsp_tag(rsp_tag3), .rsp_data(rsp_data3),
        .err_bad_idx(err3), .stat_issued(stat3)
    );

    typedef struct {
        logic [41:0] addr;
        logic [15:0] mdata;
    } tx_t;

    typedef struct {
        logic [TW-1:0]  tag;
        logic [511:0]   data;
    } rsp_t;

    tx_t         txq[$];
    rsp_t        rspq[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          m_ptr;
    int          m_outst[N];
    logic [31:0] m_stat[N];
    logic        m_err;

    task automatic chk(input string name, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_err = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_outst[i] = 0;
            m_stat[i]  = '0;
        end
        txq.delete();
        rspq.delete();
    endtask

    // One clock: drive inputs, check the grant at negedge, check registered outputs after posedge.
    task automatic step(input logic [N-1:0] v, input logic a, input logic rv, input logic [15:0] rm);
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_rsp;
        int           hs_i;
        int           j;
        int           ridx;
        tx_t          t;
        rsp_t         r;
        tx_t          gt;
        rsp_t         gr;

        req_valid = v;
        af        = a;
        rxv       = rv;
        rxm       = rm;
        rxd       = {16{$urandom}};
        for (int i = 0; i < N; i++) begin
            req_addr[i*42 +: 42] = {26'(cyc), 16'(i)};
            req_tag[i*TW +: TW]  = TW'(cyc * 4 + i + 12'h300);
        end

        @(negedge clk);
        exp_rdy = '0;
        exp_rsp = '0;
        hs_i    = -1;
        if (!a) begin
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (hs_i < 0 && v[j] && m_outst[j] < MO) hs_i = j;
            end
        end
        if (hs_i >= 0) exp_rdy[hs_i] = 1'b1;
        chk("req_ready", 512'(req_ready), 512'(exp_rdy));

        if (rv) begin
            ridx = int'(rm[TW +: 2]);
            exp_rsp[ridx] = 1'b1;
            r.tag  = rm[TW-1:0];
            r.data = rxd;
            rspq.push_back(r);
            if (m_outst[ridx] > 0) m_outst[ridx]--;
            else m_err = 1'b1;
        end
        if (hs_i >= 0) begin
            t.addr  = req_addr[hs_i*42 +: 42];
            t.mdata = {2'b00, 2'(hs_i), req_tag[hs_i*TW +: TW]};
            txq.push_back(t);
            m_ptr = (hs_i + 1) % N;
            m_outst[hs_i]++;
            m_stat[hs_i] = m_stat[hs_i] + 32'd1;
        end

        @(posedge clk);
        #1;
        chk("tx_valid", 512'(tx_vld), 512'(hs_i >= 0));
        if (tx_vld === 1'b1 && txq.size() > 0) begin
            gt = txq.pop_front();
            chk("tx_addr", 512'(tx_addr), 512'(gt.addr));
            chk("tx_mdata", 512'(tx_mdata), 512'(gt.mdata));
        end
        chk("rsp_valid", 512'(rsp_valid), 512'(exp_rsp));
        if (rsp_valid !== '0 && rspq.size() > 0) begin
            gr = rspq.pop_front();
            chk("rsp_tag", 512'(rsp_tag), 512'(gr.tag));
            chk("rsp_data", rsp_data, gr.data);
        end
        chk("err_bad_idx", 512'(err), 512'(m_err));
`ifdef SMEM_RD_ARB_STATS_EN
        for (int i = 0; i < N; i++) chk("stat_issued", 512'(stat[i*32 +: 32]), 512'(m_stat[i]));
`else
        chk("stat_issued_tied", 512'(stat), 512'(0));
`endif
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < N; i++) begin
            while (m_outst[i] > 0) step('0, 1'b0, 1'b1, {2'b00, 2'(i), 12'(m_outst[i] + 12'h0A0)});
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_tx_valid", 512'(tx_vld), 512'(0));
        chk("rst_tx_addr", 512'(tx_addr), 512'(0));
        chk("rst_tx_mdata", 512'(tx_mdata), 512'(0));
        chk("rst_rsp_valid", 512'(rsp_valid), 512'(0));
        chk("rst_rsp_tag", 512'(rsp_tag), 512'(0));
        chk("rst_rsp_data", rsp_data, 512'(0));
        chk("rst_err", 512'(err), 512'(0));
        chk("rst_stat", 512'(stat), 512'(0));
        chk("rst_err3", 512'(err3), 512'(0));
        chk("rst_rsp_valid3", 512'(rsp_valid3), 512'(0));
    endtask

    initial begin
        rst_n     = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_tag   = '0;
        af        = 1'b0;
        rxv       = 1'b0;
        rxm       = '0;
        rxd       = '0;
        rxv3      = 1'b0;
        rxm3      = '0;
        model_reset();

        #2 rst_n = 1'b0;
        #2 chk_reset_outputs();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Full contention: grants rotate 0,1,2,3,...
        repeat (8) step(4'hF, 1'b0, 1'b0, 16'h0);

        // Reset in the middle of a burst; the first grant afterwards is requester 0.
        rst_n = 1'b0;
        #2 chk_reset_outputs();
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) step(4'hF, 1'b0, 1'b0, 16'h0);
        drain();

        // Requester 1 fills its window, then is skipped without bubbles.
        repeat (MO) step(4'b0010, 1'b0, 1'b0, 16'h0);
        repeat (6) step(4'hF, 1'b0, 1'b0, 16'h0);
        step(4'hF, 1'b0, 1'b1, 16'h1005);
        repeat (4) step(4'hF, 1'b0, 1'b0, 16'h0);

        // Almost-full stalls everything; grants resume at the held pointer.
        repeat (10) step(4'hF, 1'b1, 1'b0, 16'h0);
        repeat (4) step(4'hF, 1'b0, 1'b0, 16'h0);
        drain();

        // Same-cycle issue and response on requester 2 leaves exactly one slot.
        repeat (MO - 1) step(4'b0100, 1'b0, 1'b0, 16'h0);
        step(4'b0100, 1'b0, 1'b1, 16'h2ABC);
        repeat (3) step(4'b0100, 1'b0, 1'b0, 16'h0);
        drain();

        // Response with nothing outstanding: delivered, flagged, error sticks.
        step('0, 1'b0, 1'b1, 16'h0123);
        repeat (2) step(4'hF, 1'b0, 1'b0, 16'h0);
        drain();

        // Out-of-range index on the three-requester instance.
        chk("err3_before", 512'(err3), 512'(0));
        rxv3 = 1'b1;
        rxm3 = 16'h3ABC;
        @(posedge clk);
        #1 rxv3 = 1'b0;
        chk("bad_idx_rsp_valid3", 512'(rsp_valid3), 512'(0));
        chk("bad_idx_err3", 512'(err3), 512'(1));
        repeat (3) @(posedge clk);
        #1;
        chk("bad_idx_err3_sticky", 512'(err3), 512'(1));
        chk("bad_idx_rsp_valid3_idle", 512'(rsp_valid3), 512'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
